// File: rtl/nexus_pkg.sv
// nexus_pkg: shared constants, operation encoding and the round-apply rule for
// the NexusHash lane adder datapath.
//   NEXUS_*        default geometry of the lane adder
//   nexus_op_e     ADD / SUB selector carried with each beat
//   nexus_apply()  1 when a round performs arithmetic, 0 when it bypasses A
package nexus_pkg;

  localparam int unsigned NEXUS_LANES   = 16;
  localparam int unsigned NEXUS_LANE_W  = 64;
  localparam int unsigned NEXUS_SEG_W   = 32;
  localparam int unsigned NEXUS_PERIOD  = 4;
  localparam int unsigned NEXUS_ROUND_W = 8;

  typedef enum logic {
    NEXUS_ADD = 1'b0,
    NEXUS_SUB = 1'b1
  } nexus_op_e;

  // A round applies arithmetic when it is a multiple of the period.
  function automatic logic nexus_apply(input logic [NEXUS_ROUND_W-1:0] round,
                                       input int unsigned period);
    int unsigned r;
    r = 32'(round);
    return (r % period) == 32'd0;
  endfunction

endpackage

// File: rtl/nexus_lane_adder_if.sv
// nexus_lane_adder_if: input/output handshake bundle of the lane adder.
//   in_valid/in_ready   input beat handshake
//   in_round, in_op     round number and ADD/SUB selector of the beat
//   in_a, in_b          operands, lane 0 in the least-significant LANE_W bits
//   out_valid/out_ready result beat handshake
//   out_data            per-lane result
//   out_applied         1 = arithmetic applied, 0 = A passed through
// master: beat producer / result consumer. slave: the adder.
interface nexus_lane_adder_if
  import nexus_pkg::*;
#(
  parameter int unsigned LANES  = NEXUS_LANES,
  parameter int unsigned LANE_W = NEXUS_LANE_W
);

  logic                      in_valid;
  logic                      in_ready;
  logic [NEXUS_ROUND_W-1:0]  in_round;
  logic                      in_op;
  logic [LANES*LANE_W-1:0]   in_a;
  logic [LANES*LANE_W-1:0]   in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*LANE_W-1:0]   out_data;
  logic                      out_applied;

  modport master (
    output in_valid, in_round, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_applied
  );

  modport slave (
    input  in_valid, in_round, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_applied
  );

endinterface

// File: rtl/nexus_seg_add.sv
// nexus_seg_add: one carry-resolution step of the lane adder. Adds one SEG_W-bit
// segment of every lane in parallel, each with its own carry-in.
//   a_i, b_i  LANES packed SEG_W-bit segments
//   cin_i     per-lane carry-in
//   sum_o     per-lane segment sum (mod 2^SEG_W)
//   cout_o    per-lane carry-out of the segment MSB
module nexus_seg_add
  import nexus_pkg::*;
#(
  parameter int unsigned LANES = NEXUS_LANES,
  parameter int unsigned SEG_W = NEXUS_SEG_W
) (
  input  logic [LANES*SEG_W-1:0] a_i,
  input  logic [LANES*SEG_W-1:0] b_i,
  input  logic [LANES-1:0]       cin_i,
  output logic [LANES*SEG_W-1:0] sum_o,
  output logic [LANES-1:0]       cout_o
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SEG_W:0] sum;

    assign sum = {1'b0, a_i[l*SEG_W +: SEG_W]}
               + {1'b0, b_i[l*SEG_W +: SEG_W]}
               + {{SEG_W{1'b0}}, cin_i[l]};

    assign sum_o[l*SEG_W +: SEG_W] = sum[SEG_W-1:0];
    assign cout_o[l]               = sum[SEG_W];
  end

endmodule

// File: rtl/nexus_lane_adder.sv
// nexus_lane_adder: pipelined lane-wise adder/subtractor for the NexusHash round.
// Each beat is registered on acceptance, then STAGES carry-resolution stages each
// settle one SEG_W-bit segment of every lane; the last stage register is the
// output register. Rounds that do not apply pass operand A through unchanged.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset; drops every in-flight beat
//   bus    slave side of nexus_lane_adder_if (in_* beat in, out_* result out)
module nexus_lane_adder
  import nexus_pkg::*;
#(
  parameter int unsigned LANES  = NEXUS_LANES,
  parameter int unsigned LANE_W = NEXUS_LANE_W,
  parameter int unsigned SEG_W  = NEXUS_SEG_W,
  parameter int unsigned PERIOD = NEXUS_PERIOD
) (
  input logic               clk,
  input logic               rst_n,
  nexus_lane_adder_if.slave bus
);

  localparam int unsigned STAGES = LANE_W / SEG_W;
  localparam int unsigned W      = LANES * LANE_W;

  logic adv;
  logic out_valid;

  // Single global advance: the whole pipeline moves or holds together.
  assign out_valid    = g_stage[STAGES-1].valid_q;
  assign adv          = !out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Acceptance register: the apply decision is taken on the accepted round.
  logic      in_valid_q;
  logic      in_apply_q;
  nexus_op_e in_op_q;
  logic [W-1:0] in_a_q;
  logic [W-1:0] in_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      in_apply_q <= 1'b0;
      in_op_q    <= NEXUS_ADD;
      in_a_q     <= '0;
      in_b_q     <= '0;
    end else if (adv) begin
      in_valid_q <= bus.in_valid;
      in_apply_q <= nexus_apply(bus.in_round, PERIOD);
      in_op_q    <= nexus_op_e'(bus.in_op);
      in_a_q     <= bus.in_a;
      in_b_q     <= bus.in_b;
    end
  end

  // Bypass forces B to zero with no carry-in so every stage reproduces A exactly.
  // SUB is a + ~b + 1, the +1 entering as the stage-0 carry of every lane.
  logic         sub0;
  logic [W-1:0] b0;

  assign sub0 = in_apply_q && (in_op_q == NEXUS_SUB);

  always_comb begin
    b0 = '0;
    if (in_apply_q) begin
      b0 = sub0 ? ~in_b_q : in_b_q;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Per lane, B bits still to be consumed on entry to this stage.
    localparam int unsigned RIN = (STAGES - k) * SEG_W;

    logic                   src_valid;
    logic                   src_apply;
    logic [W-1:0]           src_data;
    logic [LANES*RIN-1:0]   src_b;
    logic [LANES-1:0]       src_c;

    logic [LANES*SEG_W-1:0] seg_a;
    logic [LANES*SEG_W-1:0] seg_b;
    logic [LANES*SEG_W-1:0] seg_sum;
    logic [LANES-1:0]       seg_cout;

    logic [W-1:0]           data_d;
    logic                   valid_q;
    logic                   apply_q;
    logic [W-1:0]           data_q;

    if (k == 0) begin : g_src
      assign src_valid = in_valid_q;
      assign src_apply = in_apply_q;
      assign src_data  = in_a_q;
      assign src_b     = b0;
      assign src_c     = {LANES{sub0}};
    end else begin : g_src
      assign src_valid = g_stage[k-1].valid_q;
      assign src_apply = g_stage[k-1].apply_q;
      assign src_data  = g_stage[k-1].data_q;
      assign src_b     = g_stage[k-1].g_fwd.b_q;
      assign src_c     = g_stage[k-1].g_fwd.carry_q;
    end

    // data carries A with segments below k already replaced by the result.
    always_comb begin
      seg_a = '0;
      seg_b = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        seg_a[l*SEG_W +: SEG_W] = src_data[l*LANE_W + k*SEG_W +: SEG_W];
        seg_b[l*SEG_W +: SEG_W] = src_b[l*RIN +: SEG_W];
      end
    end

    nexus_seg_add #(
      .LANES (LANES),
      .SEG_W (SEG_W)
    ) u_seg_add (
      .a_i    (seg_a),
      .b_i    (seg_b),
      .cin_i  (src_c),
      .sum_o  (seg_sum),
      .cout_o (seg_cout)
    );

    always_comb begin
      data_d = src_data;
      for (int unsigned l = 0; l < LANES; l++) begin
        data_d[l*LANE_W + k*SEG_W +: SEG_W] = seg_sum[l*SEG_W +: SEG_W];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        apply_q <= 1'b0;
        data_q  <= '0;
      end else if (adv) begin
        valid_q <= src_valid;
        apply_q <= src_apply;
        data_q  <= data_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Only the B segments not yet consumed travel on, plus the lane carries.
      localparam int unsigned ROUT = RIN - SEG_W;

      logic [LANES*ROUT-1:0] b_d;
      logic [LANES*ROUT-1:0] b_q;
      logic [LANES-1:0]      carry_q;

      always_comb begin
        b_d = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
          b_d[l*ROUT +: ROUT] = src_b[l*RIN + SEG_W +: ROUT];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q     <= '0;
          carry_q <= '0;
        end else if (adv) begin
          b_q     <= b_d;
          carry_q <= seg_cout;
        end
      end
    end else begin : g_last
      // Carry out of each lane MSB is discarded.
      logic [LANES-1:0] unused_cout;
      assign unused_cout = seg_cout;
    end
  end

  assign bus.out_valid   = out_valid;
  assign bus.out_data    = g_stage[STAGES-1].data_q;
  assign bus.out_applied = g_stage[STAGES-1].apply_q;

endmodule

// File: tb/tb_nexus_lane_adder.sv
// tb_nexus_lane_adder: directed self-checking bench for nexus_lane_adder with
// default geometry (16 lanes x 64 bits, 32-bit segments, period 4).
module tb_nexus_lane_adder;

  localparam int unsigned LANES  = 16;
  localparam int unsigned LANE_W = 64;
  localparam int unsigned SEG_W  = 32;
  localparam int unsigned PERIOD = 4;
  localparam int unsigned W      = LANES * LANE_W;

  typedef logic [W-1:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  nexus_lane_adder_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

  nexus_lane_adder #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .SEG_W  (SEG_W),
    .PERIOD (PERIOD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      for (int l = 0; l < LANES; l++) begin
        if (got[l*LANE_W +: LANE_W] !== exp[l*LANE_W +: LANE_W]) begin
          $display("FAIL %s lane %0d: got %h expected %h", tag, l,
                   got[l*LANE_W +: LANE_W], exp[l*LANE_W +: LANE_W]);
          break;
        end
      end
    end
  endtask

  function automatic vec_t fill(input logic [LANE_W-1:0] v);
    vec_t r;
    for (int l = 0; l < LANES; l++) r[l*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  // Reference: plain 64-bit add/subtract per lane on applying rounds.
  function automatic vec_t model(input logic [7:0] round, input logic op,
                                 input vec_t a, input vec_t b);
    vec_t r;
    logic [LANE_W-1:0] x, y;
    r = a;
    if (round % 8'd4 == 8'd0) begin
      for (int l = 0; l < LANES; l++) begin
        x = a[l*LANE_W +: LANE_W];
        y = b[l*LANE_W +: LANE_W];
        r[l*LANE_W +: LANE_W] = op ? x - y : x + y;
      end
    end
    return r;
  endfunction

  // One isolated beat: checks acceptance, two-edge latency and the result.
  task automatic run_beat(input string tag, input logic [7:0] round, input logic op,
                          input vec_t a, input vec_t b, input vec_t exp_data,
                          input logic exp_app);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_round  = round;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = 1'b1;
    #1 check({tag, "_rdy"}, W'(bus.in_ready), W'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    #1 check({tag, "_lat1"}, W'(bus.out_valid), W'(0));
    @(negedge clk);
    #1 check({tag, "_lat2"}, W'(bus.out_valid), W'(0));
    @(negedge clk);
    #1 check({tag, "_valid"}, W'(bus.out_valid), W'(1));
    check({tag, "_data"}, bus.out_data, exp_data);
    check({tag, "_applied"}, W'(bus.out_applied), W'(exp_app));
  endtask

  // 16 beats on rounds 0..15; optional 5-cycle out_ready drop from stall_at.
  task automatic run_stream(input string tag, input int stall_at);
    vec_t exp_q[$];
    logic app_q[$];
    vec_t a, b, held, e;
    logic held_v, started, ea;
    int sent, got, cyc;
    logic [7:0] rnd;
    held_v = 1'b0; started = 1'b0; sent = 0; got = 0; cyc = 0; held = '0;
    while (got < 16 && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      if (sent < 16) begin
        rnd = 8'(sent);
        for (int l = 0; l < LANES; l++) begin
          a[l*LANE_W +: LANE_W] = {32'hFFFF_FFF0 + 32'(sent), 32'h1000_0001 * 32'(l)};
          b[l*LANE_W +: LANE_W] = {32'(sent * l), 32'hFFFF_FFFF - 32'(l)};
        end
        bus.in_valid = 1'b1;
        bus.in_round = rnd;
        bus.in_op    = rnd[2];
        bus.in_a     = a;
        bus.in_b     = b;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid) begin
        started = 1'b1;
        if (held_v) check({tag, "_hold"}, bus.out_data, held);
        if (bus.out_ready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            check({tag, "_extra"}, W'(1), W'(0));
          end else begin
            e  = exp_q.pop_front();
            ea = app_q.pop_front();
            check($sformatf("%s_data%0d", tag, got), bus.out_data, e);
            check($sformatf("%s_app%0d", tag, got), W'(bus.out_applied), W'(ea));
          end
          got++;
        end else begin
          check({tag, "_stall_rdy"}, W'(bus.in_ready), W'(0));
          held   = bus.out_data;
          held_v = 1'b1;
        end
      end else if (started) begin
        check({tag, "_gap"}, W'(bus.out_valid), W'(1));
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_round, bus.in_op, bus.in_a, bus.in_b));
        app_q.push_back(bus.in_round % 8'd4 == 8'd0);
        sent++;
      end
      cyc++;
    end
    check({tag, "_count"}, W'(got), W'(16));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t a, b, e;
    int stale;
    bus.in_valid  = 1'b0;
    bus.in_round  = '0;
    bus.in_op     = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    #3;
    check("rst_valid", W'(bus.out_valid), W'(0));
    check("rst_applied", W'(bus.out_applied), W'(0));
    check("rst_data", bus.out_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_ready", W'(bus.in_ready), W'(1));

    // Lane 0 wraps to zero, lane 1 untouched by the carry.
    a = '0; b = '0; e = '0;
    a[63:0]   = 64'hFFFF_FFFF_FFFF_FFFF;
    a[127:64] = 64'h1111_2222_3333_4444;
    b[63:0]   = 64'h1;
    e[127:64] = 64'h1111_2222_3333_4444;
    run_beat("wrap", 8'd0, 1'b0, a, b, e, 1'b1);
    run_beat("bypass", 8'd5, 1'b0, a, b, a, 1'b0);

    run_beat("xseg_add", 8'd4, 1'b0, fill(64'h0000_0000_FFFF_FFFF), fill(64'h1),
             fill(64'h0000_0001_0000_0000), 1'b1);
    run_beat("sub_wrap", 8'd8, 1'b1, '0, fill(64'h1),
             fill(64'hFFFF_FFFF_FFFF_FFFF), 1'b1);
    run_beat("xseg_sub", 8'd12, 1'b1, fill(64'h0000_0001_0000_0000), fill(64'h1),
             fill(64'h0000_0000_FFFF_FFFF), 1'b1);
    run_beat("sub_r255", 8'd255, 1'b1, fill(64'h5), fill(64'h3), fill(64'h5), 1'b0);

    run_stream("stream", -1);
    run_stream("bp", 6);

    // Reset with one beat at the output (stalled) and one behind it.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_round  = 8'd0;
    bus.in_op     = 1'b0;
    bus.in_a      = fill(64'h1);
    bus.in_b      = fill(64'h2);
    @(negedge clk);
    bus.in_a      = fill(64'hA);
    bus.in_b      = fill(64'h14);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    @(negedge clk);
    #1 check("mrst_pre_valid", W'(bus.out_valid), W'(1));
    check("mrst_pre_data", bus.out_data, fill(64'h3));
    #1 rst_n = 1'b0;
    #1 check("mrst_valid", W'(bus.out_valid), W'(0));
    check("mrst_applied", W'(bus.out_applied), W'(0));
    check("mrst_data", bus.out_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      #1 if (bus.out_valid) stale++;
    end
    check("mrst_no_stale", W'(stale), W'(0));
    run_beat("post_rst", 8'd16, 1'b0, fill(64'h7), fill(64'h8), fill(64'hF), 1'b1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
